// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
//
// Keeps the player/com score for a one-ball paddle game. It watches the
// ball column, counts a goal once each time the ball arrives on a goal
// column, holds the game in a serve pause after every goal, and declares a
// winner when either side reaches WIN_SCORE. START restarts a finished game.
//
// Build option:
//   SCORE_KEEPER_SERVE_DELAY_EN  defined   : serve pause lasts SERVE_TICKS cycles
//                                undefined : serve pause lasts one cycle and
//                                            the pause counter is not built
//
// Parameters:
//   W           playfield width in cells; goal columns are 0 and W-1
//   WIN_SCORE   points needed to win (1..15)
//   SERVE_TICKS serve pause length in GAME_CLK cycles (1..255)
//
// Ports:
//   GAME_CLK          in   game tick clock, rising edge
//   RESET             in   synchronous active-high reset
//   BALL_X[4:0]       in   ball column
//   START             in   restart request, honoured only after a win
//   player_score_out  out  player points
//   com_score_out     out  com points
//   goal_out          out  one-cycle pulse per counted goal
//   game_run_out      out  high while the game is in play
//   winner_out[1:0]   out  00 none, 01 player, 10 com
// ---------------------------------------------------------------------------
module score_keeper #(
   parameter int W           = 20,
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_TICKS = 8
) (
   input  logic       GAME_CLK,
   input  logic       RESET,
   input  logic [4:0] BALL_X,
   input  logic       START,
   output logic [3:0] player_score_out,
   output logic [3:0] com_score_out,
   output logic       goal_out,
   output logic       game_run_out,
   output logic [1:0] winner_out
);

   // Parameter sanity checks, evaluated at elaboration only.
   if (W < 3 || W > 32) begin : gBadWidth
      $error("score_keeper: W must be in 3..32");
   end
   if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : gBadWin
      $error("score_keeper: WIN_SCORE must be in 1..15");
   end
   if (SERVE_TICKS < 1 || SERVE_TICKS > 255) begin : gBadServe
      $error("score_keeper: SERVE_TICKS must be in 1..255");
   end

   localparam logic [4:0] GOAL_LO = 5'd0;
   localparam logic [4:0] GOAL_HI = 5'(W - 1);
   localparam logic [3:0] WIN4    = 4'(WIN_SCORE);

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      SERVE     = 2'd1,
      GAME_OVER = 2'd2
   } stateType;

   stateType   stateQ, stateD;
   logic [3:0] playerQ, playerD;
   logic [3:0] comQ, comD;
   logic [1:0] winnerQ, winnerD;
   logic       goalQ, goalD;
   logic       runQ;
   logic       atGoalQ;
   logic       atGoalNow;
   logic       goalEvent;
   logic       playerGoal;
   logic [3:0] playerInc;
   logic [3:0] comInc;

`ifdef SCORE_KEEPER_SERVE_DELAY_EN
   localparam logic [7:0] SERVE_LOAD = 8'(SERVE_TICKS - 1);
   logic [7:0] cntQ, cntD;
`endif

   // Scores never pass WIN_SCORE, so they can never wrap.
   function automatic logic [3:0] satInc(input logic [3:0] s);
      logic [3:0] r;
      if (s >= WIN4) r = WIN4;
      else           r = s + 4'd1;
      return r;
   endfunction

   assign atGoalNow  = (BALL_X == GOAL_LO) || (BALL_X == GOAL_HI);
   // Only the arrival on a goal column counts; a ball parked there is ignored.
   assign goalEvent  = atGoalNow && !atGoalQ;
   assign playerGoal = (BALL_X == GOAL_HI);
   assign playerInc  = satInc(playerQ);
   assign comInc     = satInc(comQ);

   always_comb begin
      stateD  = stateQ;
      playerD = playerQ;
      comD    = comQ;
      winnerD = winnerQ;
      goalD   = 1'b0;
      unique case (stateQ)
         PLAY: begin
            if (goalEvent) begin
               goalD = 1'b1;
               if (playerGoal) begin
                  playerD = playerInc;
                  if (playerInc == WIN4) begin
                     stateD  = GAME_OVER;
                     winnerD = 2'b01;
                  end else begin
                     stateD = SERVE;
                  end
               end else begin
                  comD = comInc;
                  if (comInc == WIN4) begin
                     stateD  = GAME_OVER;
                     winnerD = 2'b10;
                  end else begin
                     stateD = SERVE;
                  end
               end
            end
         end
         SERVE: begin
`ifdef SCORE_KEEPER_SERVE_DELAY_EN
            if (cntQ == 8'd0) stateD = PLAY;
`else
            stateD = PLAY;
`endif
         end
         GAME_OVER: begin
            if (START) begin
               playerD = 4'd0;
               comD    = 4'd0;
               winnerD = 2'b00;
               stateD  = SERVE;
            end
         end
         default: stateD = SERVE;
      endcase
   end

`ifdef SCORE_KEEPER_SERVE_DELAY_EN
   // The counter sits at its load value outside SERVE, so every entry into
   // SERVE starts a full pause without a separate load strobe.
   always_comb begin
      cntD = SERVE_LOAD;
      if (stateQ == SERVE && cntQ != 8'd0) cntD = cntQ - 8'd1;
   end
`endif

   always_ff @(posedge GAME_CLK) begin
      if (RESET) begin
         stateQ  <= SERVE;
         playerQ <= 4'd0;
         comQ    <= 4'd0;
         winnerQ <= 2'b00;
         goalQ   <= 1'b0;
         runQ    <= 1'b0;
         // History starts "on goal" so a ball sitting on a goal at reset
         // is not scored.
         atGoalQ <= 1'b1;
`ifdef SCORE_KEEPER_SERVE_DELAY_EN
         cntQ    <= SERVE_LOAD;
`endif
      end else begin
         stateQ  <= stateD;
         playerQ <= playerD;
         comQ    <= comD;
         winnerQ <= winnerD;
         goalQ   <= goalD;
         // Registered decode of the current state: lags transitions by one.
         runQ    <= (stateQ == PLAY);
         atGoalQ <= atGoalNow;
`ifdef SCORE_KEEPER_SERVE_DELAY_EN
         cntQ    <= cntD;
`endif
      end
   end

   assign player_score_out = playerQ;
   assign com_score_out    = comQ;
   assign goal_out         = goalQ;
   assign game_run_out     = runQ;
   assign winner_out       = winnerQ;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

   localparam int W   = 20;
   localparam int WIN = 9;
`ifdef SCORE_KEEPER_SERVE_DELAY_EN
   localparam int SL = 8;
`else
   localparam int SL = 1;
`endif

   logic       GAME_CLK;
   logic       RESET;
   logic [4:0] BALL_X;
   logic       START;
   logic [3:0] player_score_out;
   logic [3:0] com_score_out;
   logic       goal_out;
   logic       game_run_out;
   logic [1:0] winner_out;

   score_keeper #(.W(W), .WIN_SCORE(WIN), .SERVE_TICKS(8)) dut (
      .GAME_CLK         (GAME_CLK),
      .RESET            (RESET),
      .BALL_X           (BALL_X),
      .START            (START),
      .player_score_out (player_score_out),
      .com_score_out    (com_score_out),
      .goal_out         (goal_out),
      .game_run_out     (game_run_out),
      .winner_out       (winner_out)
   );

   initial GAME_CLK = 1'b0;
   always #5 GAME_CLK = ~GAME_CLK;

   int nTests = 0;
   int nFail  = 0;

   task automatic check(input string name, input int act, input int exp);
      nTests++;
      if (act != exp) begin
         nFail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Game modes as plain integers; serveLeft counts pause cycles remaining.
   localparam int M_PLAY = 0;
   localparam int M_SERVE = 1;
   localparam int M_OVER = 2;

   int mMode, mP, mC, mWin, mServeLeft, mGoal, mRun;
   bit mLastAt;

   function automatic int minInt(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic modelStep(input bit r, input int bx, input bit st);
      bit at;
      bit ev;
      at = (bx == 0) || (bx == W - 1);
      if (r) begin
         mMode = M_SERVE; mServeLeft = SL;
         mP = 0; mC = 0; mWin = 0; mGoal = 0; mRun = 0; mLastAt = 1'b1;
         return;
      end
      mRun    = (mMode == M_PLAY) ? 1 : 0;
      mGoal   = 0;
      ev      = at && !mLastAt;
      mLastAt = at;
      if (mMode == M_PLAY) begin
         if (ev) begin
            mGoal = 1;
            if (bx == W - 1) mP = minInt(mP + 1, WIN);
            else             mC = minInt(mC + 1, WIN);
            if (mP == WIN || mC == WIN) begin
               mMode = M_OVER;
               mWin  = (mP == WIN) ? 1 : 2;
            end else begin
               mMode = M_SERVE; mServeLeft = SL;
            end
         end
      end else if (mMode == M_SERVE) begin
         mServeLeft--;
         if (mServeLeft == 0) mMode = M_PLAY;
      end else begin
         if (st) begin
            mP = 0; mC = 0; mWin = 0;
            mMode = M_SERVE; mServeLeft = SL;
         end
      end
   endtask

   task automatic checkModel(input string tag);
      check({tag, "_player"}, int'(player_score_out), mP);
      check({tag, "_com"},    int'(com_score_out),    mC);
      check({tag, "_goal"},   int'(goal_out),         mGoal);
      check({tag, "_run"},    int'(game_run_out),     mRun);
      check({tag, "_winner"}, int'(winner_out),       mWin);
   endtask

   // Apply one cycle of inputs, advance the model, sample 1 time unit later.
   task automatic tick(input bit r, input int bx, input bit st, input bit useModel);
      RESET  = r;
      BALL_X = 5'(bx);
      START  = st;
      @(posedge GAME_CLK);
      modelStep(r, bx, st);
      #1;
      if (useModel) checkModel("mdl");
   endtask

   // Walk the ball off goal, wait for PLAY, then land it on one goal column.
   task automatic scoreGoal(input bit forPlayer);
      int guard;
      guard = 0;
      tick(1'b0, 10, 1'b0, 1'b1);
      while (mMode != M_PLAY && guard < 600) begin
         tick(1'b0, 10, 1'b0, 1'b1);
         guard++;
      end
      if (guard >= 600) check("serve_wait_timeout", 0, 1);
      tick(1'b0, forPlayer ? (W - 1) : 0, 1'b0, 1'b1);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit rst;
      int bx;
      bit st;
      int eP, eC, eG, eR, eW;
   } vecT;

   vecT tbl[$];

   function automatic void add(input bit r, input int bx, input bit st,
                               input int eP, input int eC, input int eG,
                               input int eR, input int eW);
      vecT v;
      v.rst = r; v.bx = bx; v.st = st;
      v.eP = eP; v.eC = eC; v.eG = eG; v.eR = eR; v.eW = eW;
      tbl.push_back(v);
   endfunction

   initial begin
      RESET = 1'b1; BALL_X = 5'd10; START = 1'b0;

      // reset, serve pause, then play
      add(1, 10, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < SL; i++) add(0, 10, 0, 0, 0, 0, 0, 0);
      add(0, 10, 0, 0, 0, 0, 1, 0);
      // ball parked on player's goal: counted once, pause follows
      add(0, 19, 0, 1, 0, 1, 1, 0);
      for (int i = 0; i < SL; i++) add(0, 19, 0, 1, 0, 0, 0, 0);
      add(0, 19, 0, 1, 0, 0, 1, 0);
      add(0, 10, 0, 1, 0, 0, 1, 0);
      // com goal
      add(0, 0, 0, 1, 1, 1, 1, 0);
      // START during serve and during play has no effect
      for (int i = 0; i < SL; i++) add(0, 5, 1, 1, 1, 0, 0, 0);
      add(0, 5, 1, 1, 1, 0, 1, 0);
      // reset with the ball already on a goal column: no score afterwards
      add(1, 19, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < SL; i++) add(0, 19, 0, 0, 0, 0, 0, 0);
      add(0, 19, 0, 0, 0, 0, 1, 0);

      foreach (tbl[i]) begin
         tick(tbl[i].rst, tbl[i].bx, tbl[i].st, 1'b0);
         check($sformatf("tbl%0d_player", i), int'(player_score_out), tbl[i].eP);
         check($sformatf("tbl%0d_com", i),    int'(com_score_out),    tbl[i].eC);
         check($sformatf("tbl%0d_goal", i),   int'(goal_out),         tbl[i].eG);
         check($sformatf("tbl%0d_run", i),    int'(game_run_out),     tbl[i].eR);
         check($sformatf("tbl%0d_winner", i), int'(winner_out),       tbl[i].eW);
      end

      // ---- player wins, later goals ignored ----
      tick(1'b1, 10, 1'b0, 1'b1);
      for (int i = 0; i < WIN; i++) scoreGoal(1'b1);
      check("win_player", int'(player_score_out), WIN);
      check("win_winner", int'(winner_out), 1);
      check("win_goal",   int'(goal_out), 1);
      tick(1'b0, 10, 1'b0, 1'b1);
      tick(1'b0, 0, 1'b0, 1'b1);
      check("over_com_unchanged", int'(com_score_out), 0);
      check("over_no_goal",       int'(goal_out), 0);
      check("over_run_low",       int'(game_run_out), 0);
      for (int i = 0; i < 3; i++) tick(1'b0, 10, 1'b0, 1'b1);
      check("over_holds_player", int'(player_score_out), WIN);

      // ---- restart from game over ----
      tick(1'b0, 10, 1'b1, 1'b1);
      check("start_player", int'(player_score_out), 0);
      check("start_winner", int'(winner_out), 0);
      for (int i = 0; i < SL; i++) tick(1'b0, 10, 1'b0, 1'b1);
      check("start_serve_run_low", int'(game_run_out), 0);
      tick(1'b0, 10, 1'b0, 1'b1);
      check("start_play_run_high", int'(game_run_out), 1);
      tick(1'b0, 10, 1'b1, 1'b1);
      check("start_in_play_ignored", int'(game_run_out), 1);

      // ---- reset in the middle of a serve pause at 3/2 ----
      tick(1'b1, 10, 1'b0, 1'b1);
      scoreGoal(1'b1); scoreGoal(1'b0); scoreGoal(1'b1);
      scoreGoal(1'b0); scoreGoal(1'b1);
      check("pre_rst_player", int'(player_score_out), 3);
      check("pre_rst_com",    int'(com_score_out), 2);
      for (int i = 0; i < 3; i++) tick(1'b0, 10, 1'b0, 1'b1);
      tick(1'b1, 10, 1'b0, 1'b1);
      check("rst_player", int'(player_score_out), 0);
      check("rst_com",    int'(com_score_out), 0);
      for (int i = 0; i < SL; i++) tick(1'b0, 10, 1'b0, 1'b1);
      check("rst_full_serve_low", int'(game_run_out), 0);
      tick(1'b0, 10, 1'b0, 1'b1);
      check("rst_full_serve_high", int'(game_run_out), 1);

      // ---- randomized play against the model ----
      for (int i = 0; i < 4000; i++) begin
         int  bx;
         bit  r;
         bit  st;
         int  sel;
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      bx = 0;
         else if (sel == 1) bx = W - 1;
         else               bx = int'($urandom_range(1, 31));
         r  = ($urandom_range(0, 299) == 0);
         st = ($urandom_range(0, 7) == 0);
         tick(r, bx, st, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter W, default 20, playfield width in grid cells; goal columns are 0 and W-1.
REQ-002 SHALL have parameter WIN_SCORE, default 9, points needed to win; range 1..15.
REQ-003 SHALL have parameter SERVE_TICKS, default 8, length of the post-goal hold in GAME_CLK cycles; range 1..255.
REQ-004 SHALL have port GAME_CLK input 1: the single game-tick clock; all logic on its rising edge.
REQ-005 SHALL have port RESET input 1: synchronous, active-high reset.
REQ-006 SHALL have port BALL_X input 5: ball column from the game controller.
REQ-007 SHALL have port START input 1: active-high restart request.
REQ-008 SHALL have port player_score_out output 4: player points.
REQ-009 SHALL have port com_score_out output 4: com points.
REQ-010 SHALL have port goal_out output 1: one-cycle pulse per counted goal.
REQ-011 SHALL have port game_run_out output 1: high only in PLAY; downstream uses it to gate motion.
REQ-012 SHALL have port winner_out output 2: 00 none, 01 player, 10 com.

Function
REQ-013 SHALL implement states PLAY, SERVE and GAME_OVER, all registered.
REQ-014 SHALL register at_goal = (BALL_X==0 || BALL_X==W-1) every cycle; a goal event is at_goal true now and false in the previous cycle, so a ball resting on a goal column counts once.
REQ-015 SHALL credit BALL_X==W-1 to the player and BALL_X==0 to com; both cannot occur in one cycle.
REQ-016 In PLAY, on a goal event, SHALL increment the scorer by 1 at that edge and assert goal_out for exactly the next cycle.
REQ-017 SHALL go PLAY->GAME_OVER if the incremented score equals WIN_SCORE, setting winner_out in the same edge; otherwise SHALL go PLAY->SERVE.
REQ-018 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-019 SERVE SHALL load a down-counter with SERVE_TICKS-1 on entry, decrement each cycle, and return to PLAY on the cycle after it reads 0, so SERVE lasts exactly SERVE_TICKS cycles.
REQ-020 Goal events in SERVE or GAME_OVER SHALL be ignored: no score change, no goal_out.
REQ-021 In GAME_OVER, START high SHALL clear both scores and winner_out and enter SERVE.
REQ-022 START SHALL be ignored in PLAY and SERVE.
REQ-023 game_run_out SHALL be a registered decode of the state, so it changes one cycle after the state transition.

Reset
REQ-024 RESET high at a rising edge SHALL force SERVE with the counter loaded to SERVE_TICKS-1, scores 0, winner_out 00, goal_out 0, game_run_out 0, and at_goal history 1; it takes priority over every other input.
REQ-025 RESET mid-SERVE or mid-GAME_OVER SHALL discard all progress and have the same effect as RESET at power-up.

Configuration
REQ-026 Macro SCORE_KEEPER_SERVE_DELAY_EN SHALL control the serve hold.
REQ-027 With SCORE_KEEPER_SERVE_DELAY_EN defined, SERVE SHALL behave as in REQ-019.
REQ-028 Without SCORE_KEEPER_SERVE_DELAY_EN, SERVE SHALL last exactly 1 cycle, the counter logic SHALL be omitted, SERVE_TICKS SHALL be unused, and all other behaviour SHALL be unchanged.

Verification (macro defined, defaults)
REQ-029 Reset, then BALL_X=10 for 20 cycles -> game_run_out rises after 8 SERVE cycles plus 1; scores 0/0.
REQ-030 In PLAY, BALL_X=19 for 3 cycles -> player_score_out=1 once, goal_out high 1 cycle, game_run_out low for 8 cycles.
REQ-031 Player at 8, BALL_X 10->19 -> player_score_out=9, winner_out=01, GAME_OVER; further BALL_X=0 leaves com_score_out unchanged.
REQ-032 In GAME_OVER, pulse START 1 cycle -> scores 0/0, winner_out=00, SERVE then PLAY; START in PLAY has no effect.
REQ-033 Assert RESET in the 4th SERVE cycle with score 3/2 -> next cycle scores 0/0, SERVE restarts with the full 8 cycles.
REQ-034 Rebuild without the macro, BALL_X=0 in PLAY -> com_score_out=1, game_run_out low for exactly 1 cycle.
